// File: rtl/d_kes_dc_sequencer_pkg.sv
// rtl/d_kes_dc_sequencer_pkg.sv - shared KES discrepancy-computation parameters and state encoding
//
// Purpose: field width, PE count, iteration count and the one-hot state
// encoding used by the DC sequencer and its benches.
// Ports: none (package).

package d_kes_dc_sequencer_pkg;

  localparam int GF_ORDER = 12;  // GF(2^m) symbol width
  localparam int NUM_PE   = 15;  // number of PE_DC instances (T+1)
  localparam int T        = 14;  // BM iterations per codeword
  localparam int CNT_W    = 4;   // iteration counter width

  // One-hot: each output is a single-bit decode of a state flop.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_EXEC = 5'b00010,
    ST_ACC  = 5'b00100,
    ST_OUT  = 5'b01000,
    ST_DONE = 5'b10000
  } dc_state_t;

endpackage

// File: rtl/d_kes_dc_sequencer_xor_tree.sv
// rtl/d_kes_dc_sequencer_xor_tree.sv - N-input GF(2^m) adder (bitwise XOR reduction)
//
// Purpose: sums NUM_IN symbols of W bits in GF(2^m); addition is XOR.
// Ports:
//   i_data  in  NUM_IN*W  concatenated symbols, symbol j at [j*W +: W]
//   o_sum   out W         XOR of all symbols (combinational)

module d_kes_dc_sequencer_xor_tree #(
  parameter int NUM_IN = 15,
  parameter int W      = 12
) (
  input  logic [NUM_IN*W-1:0] i_data,
  output logic [W-1:0]        o_sum
);

  always_comb begin
    o_sum = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      o_sum = o_sum ^ i_data[j*W +: W];
    end
  end

endmodule

// File: rtl/d_kes_dc_sequencer.sv
// rtl/d_kes_dc_sequencer.sv - KES discrepancy-computation PE array sequencer
//
// Purpose: per BM iteration, strobes the PE_DC array, XOR-sums the PE
// coefficients into the discrepancy and hands it to the update unit over a
// valid/ready handshake; runs T iterations per codeword and pulses done.
// Ports:
//   i_clk            in  1               rising-edge clock
//   i_RESET_KES      in  1               synchronous active-high reset
//   i_stop_dec       in  1               synchronous abort (same effect as reset)
//   i_start          in  1               begin iterations (honoured in IDLE only)
//   i_coef_bus       in  NUM_PE*GF_ORDER PE coefficient outputs
//   o_EXECUTE_PE_DC  out 1               PE execute strobe
//   o_discrepancy    out GF_ORDER        registered discrepancy
//   o_dis_valid      out 1               discrepancy valid
//   i_dis_ready      in  1               update unit accepts discrepancy
//   o_iter_cnt       out CNT_W           current iteration 0..T-1
//   o_busy           out 1               not IDLE
//   o_done           out 1               one-cycle completion pulse

module d_kes_dc_sequencer
  import d_kes_dc_sequencer_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_RESET_KES,
  input  logic                       i_stop_dec,
  input  logic                       i_start,
  input  logic [NUM_PE*GF_ORDER-1:0] i_coef_bus,
  output logic                       o_EXECUTE_PE_DC,
  output logic [GF_ORDER-1:0]        o_discrepancy,
  output logic                       o_dis_valid,
  input  logic                       i_dis_ready,
  output logic [CNT_W-1:0]           o_iter_cnt,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(T - 1);

  dc_state_t           r_state;
  logic [GF_ORDER-1:0] r_dis;
  logic [CNT_W-1:0]    r_iter_cnt;
  logic [GF_ORDER-1:0] w_coef_sum;

  d_kes_dc_sequencer_xor_tree #(
    .NUM_IN (NUM_PE),
    .W      (GF_ORDER)
  ) u_xor_tree (
    .i_data (i_coef_bus),
    .o_sum  (w_coef_sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_RESET_KES || i_stop_dec) begin
      r_state    <= ST_IDLE;
      r_dis      <= '0;
      r_iter_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_EXEC;
            r_iter_cnt <= '0;
          end
        end
        // PEs latch their inputs at the end of the strobe cycle.
        ST_EXEC: r_state <= ST_ACC;
        // PE coefficients are valid one cycle after the strobe.
        ST_ACC: begin
          r_dis   <= w_coef_sum;
          r_state <= ST_OUT;
        end
        // Hold r_dis until accepted; zero discrepancies are not skipped.
        ST_OUT: begin
          if (i_dis_ready) begin
            if (r_iter_cnt == LAST_ITER) begin
              r_state <= ST_DONE;
            end else begin
              r_iter_cnt <= r_iter_cnt + 1'b1;
              r_state    <= ST_EXEC;
            end
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_iter_cnt <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode flops only: no input-to-output combinational path.
  assign o_EXECUTE_PE_DC = (r_state == ST_EXEC);
  assign o_dis_valid     = (r_state == ST_OUT);
  assign o_done          = (r_state == ST_DONE);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_discrepancy   = r_dis;
  assign o_iter_cnt      = r_iter_cnt;

endmodule

// File: tb/tb_d_kes_dc_sequencer.sv
// tb/tb_d_kes_dc_sequencer.sv - self-checking bench for the KES DC sequencer

module tb_d_kes_dc_sequencer;
  import d_kes_dc_sequencer_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_kes;
  logic                       stop_dec;
  logic                       start;
  logic [NUM_PE*GF_ORDER-1:0] coef_bus;
  logic                       execute;
  logic [GF_ORDER-1:0]        disc;
  logic                       dis_valid;
  logic                       dis_ready;
  logic [CNT_W-1:0]           iter_cnt;
  logic                       busy;
  logic                       done;

  int n_cmp = 0;
  int n_err = 0;
  int xfers = 0;
  logic [15:0] sb[$];  // {iter_cnt, discrepancy} per expected transfer

  always #5 clk = ~clk;

  d_kes_dc_sequencer dut (
    .i_clk           (clk),
    .i_RESET_KES     (reset_kes),
    .i_stop_dec      (stop_dec),
    .i_start         (start),
    .i_coef_bus      (coef_bus),
    .o_EXECUTE_PE_DC (execute),
    .o_discrepancy   (disc),
    .o_dis_valid     (dis_valid),
    .i_dis_ready     (dis_ready),
    .o_iter_cnt      (iter_cnt),
    .o_busy          (busy),
    .o_done          (done)
  );

  function automatic logic [GF_ORDER-1:0] model_xor(input logic [NUM_PE*GF_ORDER-1:0] bus);
    logic [GF_ORDER-1:0] s;
    s = '0;
    for (int j = 0; j < NUM_PE; j++) s = s ^ bus[j*GF_ORDER +: GF_ORDER];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfer decided from outputs and ready as they will be sampled at the next edge.
  task automatic step();
    if (dis_valid && dis_ready) begin
      xfers++;
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("xfer", {16'd0, iter_cnt, disc}, {16'd0, sb.pop_front()});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_run(input logic [NUM_PE*GF_ORDER-1:0] bus);
    sb.delete();
    xfers = 0;
    for (int i = 0; i < T; i++) sb.push_back({4'(i), model_xor(bus)});
  endtask

  function automatic logic [7:0] exp_trace(input int c);
    logic e_exec, e_valid, e_done, e_busy;
    int   e_cnt;
    e_exec  = (c % 3 == 1) && (c <= 3*T - 2);
    e_valid = (c % 3 == 0) && (c >= 3) && (c <= 3*T);
    e_done  = (c == 3*T + 1);
    e_busy  = (c >= 1) && (c <= 3*T + 1);
    e_cnt   = (c <= 3*T) ? (c - 1) / 3 : ((c == 3*T + 1) ? T - 1 : 0);
    return {e_exec, e_valid, e_done, e_busy, 4'(e_cnt)};
  endfunction

  task automatic run_full(input string tag, input logic [NUM_PE*GF_ORDER-1:0] bus,
                          input bit busy_starts);
    coef_bus  = bus;
    dis_ready = 1'b1;
    push_run(bus);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 3*T + 3; c++) begin
      chk({tag, "_trace"}, {24'd0, execute, dis_valid, done, busy, iter_cnt},
          {24'd0, exp_trace(c)});
      start = busy_starts && (c == 4 || c == 6 || c == 10 || c == 21);
      step();
    end
    start = 1'b0;
    chk({tag, "_sb_drained"}, sb.size(), 0);
    chk({tag, "_xfer_count"}, xfers, T);
  endtask

  logic [NUM_PE*GF_ORDER-1:0] bus_a;
  logic [GF_ORDER-1:0]        exp_dis;
  bit                         done_seen;

  initial begin
    reset_kes = 1'b1;
    stop_dec  = 1'b0;
    start     = 1'b0;
    coef_bus  = '0;
    dis_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {8'd0, execute, dis_valid, done, busy, iter_cnt, disc}, 32'd0);
    reset_kes = 1'b0;
    step();
    chk("idle_after_reset", {8'd0, execute, dis_valid, done, busy, iter_cnt, disc}, 32'd0);

    // Single-iteration sum 1^2^4, then let the run finish.
    bus_a = '0;
    bus_a[0*GF_ORDER +: GF_ORDER] = 12'h001;
    bus_a[1*GF_ORDER +: GF_ORDER] = 12'h002;
    bus_a[2*GF_ORDER +: GF_ORDER] = 12'h004;
    coef_bus = bus_a;
    push_run(bus_a);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("single_exec_c1", execute, 1'b1);
    step();
    chk("single_exec_c2", execute, 1'b0);
    step();
    chk("single_valid_c3", dis_valid, 1'b1);
    chk("single_disc_c3", disc, 12'h007);
    chk("single_cnt_c3", iter_cnt, 0);
    done_seen = 1'b0;
    for (int k = 0; k < 100 && !done_seen; k++) begin
      step();
      done_seen = done;
    end
    chk("single_done_seen", done_seen, 1'b1);
    step();
    chk("single_sb_drained", sb.size(), 0);

    // Full run, all coefs FFF (odd PE count -> FFF), with and without stray starts.
    bus_a = '1;
    run_full("full", bus_a, 1'b0);
    chk("full_busy_after", busy, 1'b0);
    run_full("busy_start", bus_a, 1'b1);

    // Backpressure in OUT of iteration 2.
    for (int j = 0; j < NUM_PE; j++) bus_a[j*GF_ORDER +: GF_ORDER] = GF_ORDER'($urandom);
    coef_bus = bus_a;
    exp_dis  = model_xor(bus_a);
    push_run(bus_a);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 9; c++) step();
    chk("bp_valid_c9", dis_valid, 1'b1);
    chk("bp_cnt_c9", iter_cnt, 2);
    dis_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold", {16'd0, dis_valid, execute, iter_cnt, disc},
          {16'd0, 1'b1, 1'b0, 4'd2, exp_dis});
    end
    dis_ready = 1'b1;
    step();
    chk("bp_exec_after", execute, 1'b1);
    chk("bp_cnt_after", iter_cnt, 3);
    done_seen = 1'b0;
    for (int k = 0; k < 100 && !done_seen; k++) begin
      step();
      done_seen = done;
    end
    chk("bp_done_seen", done_seen, 1'b1);
    chk("bp_sb_drained", sb.size(), 0);
    chk("bp_xfer_count", xfers, T);
    step();

    // Abort in ACC of iteration 5.
    bus_a = '0;
    bus_a[7*GF_ORDER +: GF_ORDER] = 12'hA5C;
    bus_a[3*GF_ORDER +: GF_ORDER] = 12'h0F0;
    coef_bus = bus_a;
    push_run(bus_a);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 17; c++) step();
    chk("abort_in_acc_cnt", iter_cnt, 5);
    stop_dec = 1'b1;
    step();
    stop_dec = 1'b0;
    chk("abort_outputs", {8'd0, execute, dis_valid, done, busy, iter_cnt, disc}, 32'd0);
    chk("abort_xfers", xfers, 5);
    sb.delete();
    done_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      done_seen = done_seen | done | busy;
    end
    chk("abort_no_done", done_seen, 1'b0);
    bus_a[9*GF_ORDER +: GF_ORDER] = 12'h3C3;
    run_full("restart", bus_a, 1'b0);

    // Reset has priority over start in IDLE.
    reset_kes = 1'b1;
    start     = 1'b1;
    step();
    reset_kes = 1'b0;
    start     = 1'b0;
    chk("rst_prio", {8'd0, execute, dis_valid, done, busy, iter_cnt, disc}, 32'd0);
    step();
    chk("rst_prio_idle", busy, 1'b0);

    run_full("zero", '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
